// File: rtl/hashmap_update_ctrl.sv
// hashmap_update_ctrl: read-modify-write sequencer in front of a pipelined hashmap.
// Accepted requests look up immediately, resolve NUM_PIPES cycles later (modify/delete
// on a hit, queue an insert on an update miss) and respond one cycle after resolve.
// A key hazard stall keeps a second lookup of a key from racing its own pending insert.
module hashmap_update_ctrl #(
  parameter int NUM_KEY_BITS = 8,
  parameter int NUM_VAL_BITS = 8,
  parameter int NUM_PIPES    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NUM_KEY_BITS-1:0] req_key,
  input  logic [NUM_VAL_BITS-1:0] req_delta,
  input  logic                    req_clear,
  output logic                    rsp_valid,
  output logic [NUM_KEY_BITS-1:0] rsp_key,
  output logic                    rsp_hit,
  output logic [NUM_VAL_BITS-1:0] rsp_value,
  output logic                    hm_lookup,
  output logic [NUM_KEY_BITS-1:0] hm_key,
  output logic                    hm_modify,
  output logic                    hm_del,
  output logic [NUM_VAL_BITS-1:0] hm_mod_value,
  input  logic                    hm_valid,
  input  logic [NUM_VAL_BITS-1:0] hm_value,
  output logic                    hm_insert,
  output logic [NUM_KEY_BITS-1:0] hm_ins_key,
  output logic [NUM_VAL_BITS-1:0] hm_ins_value,
  input  logic                    hm_busy
);

  localparam int PTR_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int CNT_W = $clog2(NUM_PIPES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_PIPES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_PIPES);

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [NUM_VAL_BITS-1:0] sat_add(
    input logic [NUM_VAL_BITS-1:0] a,
    input logic [NUM_VAL_BITS-1:0] b
  );
    logic [NUM_VAL_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = sum[NUM_VAL_BITS] ? {NUM_VAL_BITS{1'b1}} : sum[NUM_VAL_BITS-1:0];
  endfunction

  // In-flight shift register; the last stage is the one resolving this cycle.
  logic [NUM_PIPES-1:0]    stg_valid_r;
  logic [NUM_PIPES-1:0]    stg_clear_r;
  logic [NUM_KEY_BITS-1:0] stg_key_r   [NUM_PIPES];
  logic [NUM_VAL_BITS-1:0] stg_delta_r [NUM_PIPES];

  // Pending-insert FIFO with a per-slot valid bit for the key hazard compare.
  logic [NUM_KEY_BITS-1:0] fifo_key_r   [NUM_PIPES];
  logic [NUM_VAL_BITS-1:0] fifo_delta_r [NUM_PIPES];
  logic [NUM_PIPES-1:0]    fifo_vld_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [CNT_W-1:0]        cnt_r;

  logic                    rsp_valid_r;
  logic                    rsp_hit_r;
  logic [NUM_KEY_BITS-1:0] rsp_key_r;
  logic [NUM_VAL_BITS-1:0] rsp_value_r;

  logic                    key_hazard_s;
  logic                    fifo_empty_s;
  logic                    res_valid_s;
  logic                    res_clear_s;
  logic [NUM_KEY_BITS-1:0] res_key_s;
  logic [NUM_VAL_BITS-1:0] res_delta_s;
  logic [NUM_VAL_BITS-1:0] rsp_value_s;
  logic                    push_s;
  logic                    deq_s;
  logic                    byp_s;
  logic                    enq_s;

  assign fifo_empty_s = (cnt_r == {CNT_W{1'b0}});
  assign res_valid_s  = stg_valid_r[NUM_PIPES-1] & ~rst;
  assign res_clear_s  = stg_clear_r[NUM_PIPES-1];
  assign res_key_s    = stg_key_r[NUM_PIPES-1];
  assign res_delta_s  = stg_delta_r[NUM_PIPES-1];

  // Flag a request key that matches any live in-flight entry or pending insert.
  always_comb begin
    key_hazard_s = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      key_hazard_s = key_hazard_s
                   | (stg_valid_r[i] & (stg_key_r[i] == req_key))
                   | (fifo_vld_r[i] & (fifo_key_r[i] == req_key));
    end
  end

  assign req_ready = ~rst & ~key_hazard_s & fifo_empty_s;
  assign hm_lookup = req_valid & req_ready;
  assign hm_key    = rst ? {NUM_KEY_BITS{1'b0}} : req_key;

  // Resolve the oldest entry: modify/delete on a hit, request an insert on an update miss.
  always_comb begin
    hm_modify    = 1'b0;
    hm_del       = 1'b0;
    hm_mod_value = {NUM_VAL_BITS{1'b0}};
    push_s       = 1'b0;
    rsp_value_s  = {NUM_VAL_BITS{1'b0}};
    if (res_valid_s) begin
      if (hm_valid) begin
        hm_modify = 1'b1;
        if (res_clear_s) begin
          hm_del      = 1'b1;
          rsp_value_s = hm_value;
        end else begin
          hm_mod_value = sat_add(hm_value, res_delta_s);
          rsp_value_s  = sat_add(hm_value, res_delta_s);
        end
      end else begin
        if (res_clear_s) begin
          rsp_value_s = {NUM_VAL_BITS{1'b0}};
        end else begin
          rsp_value_s = res_delta_s;
          push_s      = (res_delta_s != {NUM_VAL_BITS{1'b0}});
        end
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Issue one insert per cycle: FIFO head first, else bypass a fresh miss straight through.
  always_comb begin
    deq_s        = 1'b0;
    byp_s        = 1'b0;
    hm_insert    = 1'b0;
    hm_ins_key   = {NUM_KEY_BITS{1'b0}};
    hm_ins_value = {NUM_VAL_BITS{1'b0}};
    if (rst || hm_busy) begin
      hm_insert = 1'b0;
    end else if (!fifo_empty_s) begin
      deq_s        = 1'b1;
      hm_insert    = 1'b1;
      hm_ins_key   = fifo_key_r[rd_ptr_r];
      hm_ins_value = fifo_delta_r[rd_ptr_r];
    end else if (push_s) begin
      byp_s        = 1'b1;
      hm_insert    = 1'b1;
      hm_ins_key   = res_key_s;
      hm_ins_value = res_delta_s;
    end else begin
      hm_insert = 1'b0;
    end
  end

  assign enq_s = push_s & ~byp_s;

  // Advance accepted requests through the lookup-latency pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_r <= {NUM_PIPES{1'b0}};
      stg_clear_r <= {NUM_PIPES{1'b0}};
      for (int i = 0; i < NUM_PIPES; i++) begin
        stg_key_r[i]   <= {NUM_KEY_BITS{1'b0}};
        stg_delta_r[i] <= {NUM_VAL_BITS{1'b0}};
      end
    end else begin
      stg_valid_r[0] <= hm_lookup;
      stg_clear_r[0] <= req_clear;
      stg_key_r[0]   <= req_key;
      stg_delta_r[0] <= req_delta;
      for (int i = 1; i < NUM_PIPES; i++) begin
        stg_valid_r[i] <= stg_valid_r[i-1];
        stg_clear_r[i] <= stg_clear_r[i-1];
        stg_key_r[i]   <= stg_key_r[i-1];
        stg_delta_r[i] <= stg_delta_r[i-1];
      end
    end
  end

  // Pending-insert FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      fifo_vld_r <= {NUM_PIPES{1'b0}};
      for (int i = 0; i < NUM_PIPES; i++) begin
        fifo_key_r[i]   <= {NUM_KEY_BITS{1'b0}};
        fifo_delta_r[i] <= {NUM_VAL_BITS{1'b0}};
      end
    end else begin
      if (deq_s) begin
        fifo_vld_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      if (enq_s) begin
        fifo_vld_r[wr_ptr_r]   <= 1'b1;
        fifo_key_r[wr_ptr_r]   <= res_key_s;
        fifo_delta_r[wr_ptr_r] <= res_delta_s;
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // The FIFO blocks new requests while occupied, so it can never be pushed when full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enq_s && !deq_s && (cnt_r == FULL_CNT)));
    end
  end

  // Register the response one cycle after resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_key_r   <= {NUM_KEY_BITS{1'b0}};
      rsp_value_r <= {NUM_VAL_BITS{1'b0}};
    end else begin
      rsp_valid_r <= res_valid_s;
      rsp_hit_r   <= res_valid_s & hm_valid;
      rsp_key_r   <= res_valid_s ? res_key_s : {NUM_KEY_BITS{1'b0}};
      rsp_value_r <= rsp_value_s;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_hit   = rsp_hit_r;
  assign rsp_key   = rsp_key_r;
  assign rsp_value = rsp_value_r;

endmodule

// File: tb/tb_hashmap_update_ctrl.sv
// Bench for hashmap_update_ctrl: behavioural hashmap model plus scoreboards for
// responses, modifies and inserts, with directed timing checks from the test plan.
module tb_hashmap_update_ctrl;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_clear;
  logic [7:0] req_key, req_delta;
  logic       rsp_valid, rsp_hit;
  logic [7:0] rsp_key, rsp_value;
  logic       hm_lookup, hm_modify, hm_del, hm_valid, hm_insert, hm_busy;
  logic [7:0] hm_key, hm_mod_value, hm_value, hm_ins_key, hm_ins_value;

  always #5 clk = ~clk;

  hashmap_update_ctrl #(.NUM_KEY_BITS(8), .NUM_VAL_BITS(8), .NUM_PIPES(P)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_delta(req_delta), .req_clear(req_clear),
    .rsp_valid(rsp_valid), .rsp_key(rsp_key), .rsp_hit(rsp_hit), .rsp_value(rsp_value),
    .hm_lookup(hm_lookup), .hm_key(hm_key), .hm_modify(hm_modify), .hm_del(hm_del),
    .hm_mod_value(hm_mod_value), .hm_valid(hm_valid), .hm_value(hm_value),
    .hm_insert(hm_insert), .hm_ins_key(hm_ins_key), .hm_ins_value(hm_ins_value),
    .hm_busy(hm_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_ins    = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Cycle counter for latency and throughput measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural hashmap: lookup result after P cycles, modify uses the looked-up key.
  logic       mem_v   [256];
  logic [7:0] mem_val [256];
  logic [P-1:0] pv = '0;
  logic [7:0] pk [P];
  logic       rv [P];
  logic [7:0] rval [P];
  assign hm_valid = pv[P-1] & rv[P-1];
  assign hm_value = rval[P-1];

  // Hashmap model state update.
  always @(posedge clk) begin
    pv      <= {pv[P-2:0], hm_lookup};
    pk[0]   <= hm_key;
    rv[0]   <= mem_v[hm_key];
    rval[0] <= mem_val[hm_key];
    for (int i = 1; i < P; i++) begin
      pk[i] <= pk[i-1]; rv[i] <= rv[i-1]; rval[i] <= rval[i-1];
    end
    if (hm_modify) begin
      if (hm_del) mem_v[pk[P-1]] <= 1'b0;
      else        mem_val[pk[P-1]] <= hm_mod_value;
    end
    if (hm_insert) begin
      mem_v[hm_ins_key]   <= 1'b1;
      mem_val[hm_ins_key] <= hm_ins_value;
    end
  end

  // Reference key/value map advanced at request acceptance.
  logic       ref_v   [256];
  logic [7:0] ref_val [256];

  typedef struct packed { logic [7:0] key; logic hit; logic [7:0] val; } rsp_t;
  typedef struct packed { logic del; logic [7:0] val; } mod_t;
  typedef struct packed { logic [7:0] key; logic [7:0] val; } ins_t;
  rsp_t rsp_q[$];
  mod_t mod_q[$];
  ins_t ins_q[$];

  task automatic expect_req(input logic [7:0] k, input logic [7:0] d, input logic c);
    int s;
    if (ref_v[k]) begin
      if (c) begin
        rsp_q.push_back('{key: k, hit: 1'b1, val: ref_val[k]});
        mod_q.push_back('{del: 1'b1, val: 8'h00});
        ref_v[k] = 1'b0;
      end else begin
        s = int'(ref_val[k]) + int'(d);
        if (s > 255) s = 255;
        rsp_q.push_back('{key: k, hit: 1'b1, val: 8'(s)});
        mod_q.push_back('{del: 1'b0, val: 8'(s)});
        ref_val[k] = 8'(s);
      end
    end else begin
      if (c) begin
        rsp_q.push_back('{key: k, hit: 1'b0, val: 8'h00});
      end else begin
        rsp_q.push_back('{key: k, hit: 1'b0, val: d});
        if (d != 8'h00) begin
          ins_q.push_back('{key: k, val: d});
          ref_v[k] = 1'b1;
          ref_val[k] = d;
        end
      end
    end
  endtask

  // Present a request until accepted (bounded); returns acceptance cycle, ends one cycle later.
  task automatic send(input logic [7:0] k, input logic [7:0] d, input logic c,
                      input bit track, output int acc);
    int waited = 0;
    req_valid = 1'b1; req_key = k; req_delta = d; req_clear = c;
    #1;
    while (!req_ready && waited < 30) begin
      @(negedge clk); #1; waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      acc = -1;
      req_valid = 1'b0;
    end else begin
      acc = cyc;
      check("lookup", {hm_lookup, hm_key}, {1'b1, k});
      if (track) expect_req(k, d, c);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
    end
  endtask

  // Scoreboard monitors: compare every response, modify and insert against expectations.
  always @(negedge clk) begin
    rsp_t er; mod_t em; ins_t ei;
    #4;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        er = rsp_q.pop_front();
        check("rsp_key", rsp_key, er.key);
        check("rsp_hit", rsp_hit, er.hit);
        check("rsp_value", rsp_value, er.val);
      end
    end
    if (hm_modify) begin
      if (mod_q.size() == 0) check("modify_unexpected", 32'd1, 32'd0);
      else begin
        em = mod_q.pop_front();
        check("modify_del", hm_del, em.del);
        if (!em.del) check("modify_value", hm_mod_value, em.val);
      end
    end
    if (hm_insert) begin
      n_ins++;
      if (ins_q.size() == 0) check("insert_unexpected", 32'd1, 32'd0);
      else begin
        ei = ins_q.pop_front();
        check("insert_kv", {hm_ins_key, hm_ins_value}, {ei.key, ei.val});
      end
    end
  end

  int a0, a1, a2, ins0, waited;
  int acc [8];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_v[i] = 1'b0; mem_val[i] = 8'h00; ref_v[i] = 1'b0; ref_val[i] = 8'h00;
    end
    for (int i = 0; i < P; i++) begin
      pk[i] = 8'h00; rv[i] = 1'b0; rval[i] = 8'h00;
    end
    mem_v[8'h11] = 1'b1; mem_val[8'h11] = 8'h05; ref_v[8'h11] = 1'b1; ref_val[8'h11] = 8'h05;
    mem_v[8'h44] = 1'b1; mem_val[8'h44] = 8'hF0; ref_v[8'h44] = 1'b1; ref_val[8'h44] = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      mem_v[8'h60 + i] = 1'b1; mem_val[8'h60 + i] = 8'(i);
      ref_v[8'h60 + i] = 1'b1; ref_val[8'h60 + i] = 8'(i);
    end

    // Reset: requests presented during reset must not be looked up.
    rst = 1'b1; hm_busy = 1'b0;
    req_valid = 1'b1; req_key = 8'h11; req_delta = 8'h01; req_clear = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", {req_ready, hm_lookup, rsp_valid, hm_modify, hm_del, hm_insert}, 32'd0);
    check("reset_data", {hm_key, rsp_value, hm_ins_key}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("post_reset_rsp", {rsp_valid, rsp_hit, rsp_value}, 32'd0);

    // Update hit: 0x05 + 0x03.
    @(negedge clk);
    send(8'h11, 8'h03, 1'b0, 1'b1, a0);
    @(negedge clk); #1;
    check("t1_modify", {hm_modify, hm_del, hm_mod_value}, {1'b1, 1'b0, 8'h08});
    check("t1_rsp_not_early", rsp_valid, 32'd0);
    @(negedge clk); #1;
    check("t1_rsp", {rsp_valid, rsp_hit, rsp_value}, {1'b1, 1'b1, 8'h08});

    // Miss with hashmap busy for t+2..t+5.
    @(negedge clk);
    send(8'h22, 8'h07, 1'b0, 1'b1, a0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      hm_busy = 1'b1;
      #1;
      check("t2_ready_busy", req_ready, 32'd0);
      check("t2_no_insert", hm_insert, 32'd0);
      if (c == 3) check("t2_rsp", {rsp_valid, rsp_hit, rsp_value}, {1'b1, 1'b0, 8'h07});
    end
    @(negedge clk);
    hm_busy = 1'b0;
    #1;
    check("t2_insert", {hm_insert, hm_ins_key, hm_ins_value}, {1'b1, 8'h22, 8'h07});
    check("t2_ready_t6", req_ready, 32'd0);
    @(negedge clk); #1;
    check("t2_ready_t7", req_ready, 32'd1);

    // Same-key hazard on an absent key.
    ins0 = n_ins;
    @(negedge clk);
    send(8'h33, 8'h02, 1'b0, 1'b1, a1);
    send(8'h33, 8'h05, 1'b0, 1'b1, a2);
    check("t3_stall_cycles", a2 - a1, 32'd3);
    repeat (6) @(negedge clk);
    check("t3_one_insert", n_ins - ins0, 32'd1);

    // Clear a present key, then a lookup of it misses; clear of an absent key.
    @(negedge clk);
    send(8'h11, 8'hAA, 1'b1, 1'b1, a0);
    @(negedge clk); #1;
    check("t4_del", {hm_modify, hm_del}, 32'd3);
    send(8'h11, 8'h00, 1'b0, 1'b1, a0);
    send(8'h55, 8'h09, 1'b1, 1'b1, a0);

    // Saturation: 0xF0 + 0x20 clamps to 0xFF.
    @(negedge clk);
    send(8'h44, 8'h20, 1'b0, 1'b1, a0);
    @(negedge clk); #1;
    check("t5_sat_modify", {hm_modify, hm_mod_value}, {1'b1, 8'hFF});
    @(negedge clk); #1;
    check("t5_sat_rsp", {rsp_valid, rsp_value}, {1'b1, 8'hFF});

    // Distinct present keys stream at one request per cycle.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h60 + i), 8'(i + 1), 1'b0, 1'b1, acc[i]);
      if (i > 0) check("t6_back_to_back", acc[i] - acc[i-1], 32'd1);
    end

    // Reset mid-flight drops the request: no modify, insert or response.
    repeat (4) @(negedge clk);
    @(negedge clk);
    send(8'h77, 8'h05, 1'b0, 1'b0, a0);
    rst = 1'b1;
    #1;
    check("t7_reset_cycle", {hm_modify, hm_insert, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      check("t7_outputs_zero", {rsp_valid, hm_modify, hm_del, hm_insert, hm_lookup}, 32'd0);
      @(negedge clk); #1;
    end
    send(8'h77, 8'h05, 1'b0, 1'b1, a0);

    // Let everything outstanding retire.
    waited = 0;
    while ((rsp_q.size() + mod_q.size() + ins_q.size()) != 0 && waited < 40) begin
      @(negedge clk); waited++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", rsp_q.size() + mod_q.size() + ins_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
